// File: rtl/load_store_unit_l8_pkg.sv
// Shared micro-architecture types for the load/store unit slice.
//   rv_uop       : memory micro-ops handled by the LSU
//   t_op         : memory request opcode (MEM_MSG_READ / MEM_MSG_WRITE)
//   is_store()   : true for SB/SH/SW
//   base_strb()  : byte-enable pattern for an access at offset 0
package load_store_unit_l8_pkg;

   typedef enum logic [2:0] {
      UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU, UOP_SB, UOP_SH, UOP_SW
   } rv_uop;

   typedef enum logic {
      MEM_MSG_READ  = 1'b0,
      MEM_MSG_WRITE = 1'b1
   } t_op;

   function automatic logic is_store(input rv_uop u);
      return (u == UOP_SB) || (u == UOP_SH) || (u == UOP_SW);
   endfunction

   function automatic logic [3:0] base_strb(input rv_uop u);
      case (u)
         UOP_LB, UOP_LBU, UOP_SB: return 4'b0001;
         UOP_LH, UOP_LHU, UOP_SH: return 4'b0011;
         default:                 return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_l8_if.sv
// Bus interfaces around the load/store unit.
//   D__XIntf : dispatch -> execute (val/rdy, pc, seq_num, op1..op3, waddr, preg, ppreg, uop)
//              modports D_intf (producer) and X_intf (consumer)
//   X__WIntf : execute -> writeback (val/rdy, pc, seq_num, waddr, preg, ppreg, wdata, wen)
//              modports X_intf (producer) and W_intf (consumer)
//   MemIntf  : memory request/response channels, tagged with an opaque field
//              modports client (requester) and server (memory)
interface D__XIntf #(
   parameter int p_seq_num_bits   = 5,
   parameter int p_phys_addr_bits = 6
);
   import load_store_unit_l8_pkg::*;

   logic                        val;
   logic                        rdy;
   logic [31:0]                 pc;
   logic [p_seq_num_bits-1:0]   seq_num;
   logic [31:0]                 op1;
   logic [31:0]                 op2;
   logic [31:0]                 op3;
   logic [4:0]                  waddr;
   logic [p_phys_addr_bits-1:0] preg;
   logic [p_phys_addr_bits-1:0] ppreg;
   rv_uop                       uop;

   modport D_intf (output val, pc, seq_num, op1, op2, op3, waddr, preg, ppreg, uop, input rdy);
   modport X_intf (input val, pc, seq_num, op1, op2, op3, waddr, preg, ppreg, uop, output rdy);
endinterface

interface X__WIntf #(
   parameter int p_seq_num_bits   = 5,
   parameter int p_phys_addr_bits = 6
);
   logic                        val;
   logic                        rdy;
   logic [31:0]                 pc;
   logic [p_seq_num_bits-1:0]   seq_num;
   logic [4:0]                  waddr;
   logic [p_phys_addr_bits-1:0] preg;
   logic [p_phys_addr_bits-1:0] ppreg;
   logic [31:0]                 wdata;
   logic                        wen;

   modport X_intf (output val, pc, seq_num, waddr, preg, ppreg, wdata, wen, input rdy);
   modport W_intf (input val, pc, seq_num, waddr, preg, ppreg, wdata, wen, output rdy);
endinterface

interface MemIntf #(
   parameter int p_opaq_bits = 8
);
   import load_store_unit_l8_pkg::*;

   typedef struct packed {
      t_op                    op;
      logic [p_opaq_bits-1:0] opaque;
      logic [31:0]            addr;
      logic [3:0]             strb;
      logic [31:0]            data;
   } mem_req_msg_t;

   typedef struct packed {
      logic [p_opaq_bits-1:0] opaque;
      logic [31:0]            data;
   } mem_resp_msg_t;

   logic          req_val;
   logic          req_rdy;
   mem_req_msg_t  req_msg;
   logic          resp_val;
   logic          resp_rdy;
   mem_resp_msg_t resp_msg;

   modport client (output req_val, req_msg, resp_rdy, input req_rdy, resp_val, resp_msg);
   modport server (input req_val, req_msg, resp_rdy, output req_rdy, resp_val, resp_msg);
endinterface

// File: rtl/load_store_unit_l8_load_extract.sv
// Combinational load-data extraction: aligns the raw 32-bit memory word to the
// access offset and sign- or zero-extends it according to the micro-op.
//   raw    in  32  word returned by memory
//   offset in  2   byte offset of the access inside the word
//   uop    in      memory micro-op
//   wdata  out 32  register writeback value (stores pass the shifted word through)
module lsu_load_extract
   import load_store_unit_l8_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  offset,
   input  rv_uop       uop,
   output logic [31:0] wdata
);

   logic [31:0] shifted;

   assign shifted = raw >> {offset, 3'b000};

   always_comb begin
      wdata = shifted;
      case (uop)
         UOP_LB:  wdata = {{24{shifted[7]}}, shifted[7:0]};
         UOP_LBU: wdata = {24'd0, shifted[7:0]};
         UOP_LH:  wdata = {{16{shifted[15]}}, shifted[15:0]};
         UOP_LHU: wdata = {16'd0, shifted[15:0]};
         default: wdata = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit_l8.sv
// Pipelined load/store execute unit with up to p_depth requests in flight.
// Requests are tagged with their slot index in the memory opaque field so
// responses may return in any order; results retire to writeback in issue order.
//   clk  in   clock
//   rst  in   synchronous reset, active low
//   D    in   dispatch interface (consumer side)
//   W    out  writeback interface (producer side)
//   mem  io   memory request/response channels (client side)
module load_store_unit_l8
   import load_store_unit_l8_pkg::*;
#(
   parameter int p_seq_num_bits   = 5,
   parameter int p_phys_addr_bits = 6,
   parameter int p_opaq_bits      = 8,
   parameter int p_depth          = 4
) (
   input  logic    clk,
   input  logic    rst,
   D__XIntf.X_intf D,
   X__WIntf.X_intf W,
   MemIntf.client  mem
);

   localparam int IDX_W = $clog2(p_depth);
   localparam int CNT_W = IDX_W + 1;

   if (p_depth < 2 || (p_depth & (p_depth - 1)) != 0 || p_depth > (1 << p_opaq_bits)) begin : g_bad_depth
      $error("p_depth must be a power of two, >= 2, and fit in the opaque field");
   end

   typedef struct packed {
      logic [31:0]                 pc;
      logic [p_seq_num_bits-1:0]   seq_num;
      logic [31:0]                 op1;
      logic [31:0]                 op2;
      logic [31:0]                 op3;
      logic [4:0]                  waddr;
      logic [p_phys_addr_bits-1:0] preg;
      logic [p_phys_addr_bits-1:0] ppreg;
      rv_uop                       uop;
   } req_t;

   typedef struct packed {
      logic [31:0]                 pc;
      logic [p_seq_num_bits-1:0]   seq_num;
      logic [4:0]                  waddr;
      logic [p_phys_addr_bits-1:0] preg;
      logic [p_phys_addr_bits-1:0] ppreg;
      rv_uop                       uop;
      logic [1:0]                  offset;
      logic [31:0]                 raw;
   } slot_t;

   logic               vld_p1;
   req_t               req_p1;
   slot_t              slot_p2 [p_depth];
   logic [p_depth-1:0] busy_p2;
   logic [p_depth-1:0] done_p2;
   logic [IDX_W-1:0]   head;
   logic [IDX_W-1:0]   tail;
   logic [IDX_W-1:0]   resp_idx;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   drain_cnt;
   logic               full;
   logic               d_xfer;
   logic               issue;
   logic               retire;
   logic               resp_ok;
   logic               resp_fire;
   logic [31:0]        addr;
   logic [1:0]         offset;
   logic [31:0]        ext_wdata;

   // The registered count alone decides full, so a same-cycle retire never
   // unblocks issue and there is no path from W.rdy to the memory request.
   assign full     = (count == CNT_W'(p_depth));
   assign addr     = req_p1.op1 + req_p1.op2;
   assign offset   = addr[1:0];
   assign resp_idx = mem.resp_msg.opaque[IDX_W-1:0];

   // Outputs are forced to their idle values while reset is held.
   assign mem.req_val  = rst & vld_p1 & ~full;
   assign mem.resp_rdy = 1'b1;
   assign issue        = mem.req_val & mem.req_rdy;
   assign D.rdy        = ~rst | ~vld_p1 | issue;
   assign d_xfer       = rst & D.val & D.rdy;
   assign W.val        = rst & busy_p2[head] & done_p2[head];
   assign retire       = W.val & W.rdy;

   // A response may target the slot being issued this very cycle (zero-latency memory).
   assign resp_ok   = busy_p2[resp_idx] | (issue & (tail == resp_idx));
   assign resp_fire = rst & mem.resp_val & resp_ok;

   always_comb begin
      mem.req_msg.op     = is_store(req_p1.uop) ? MEM_MSG_WRITE : MEM_MSG_READ;
      mem.req_msg.opaque = p_opaq_bits'(tail);
      mem.req_msg.addr   = {addr[31:2], 2'b00};
      mem.req_msg.strb   = base_strb(req_p1.uop) << offset;
      mem.req_msg.data   = req_p1.op3 << {offset, 3'b000};
   end

   // ---- stage 1: request register (dispatch -> issue) ----
   // ---- stage 2: slot array (issue -> response -> retire) ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_p1    <= 1'b0;
         busy_p2   <= '0;
         done_p2   <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         drain_cnt <= CNT_W'(p_depth);
      end else begin
         if (d_xfer)
            vld_p1 <= 1'b1;
         else if (issue)
            vld_p1 <= 1'b0;

         if (issue) begin
            busy_p2[tail] <= 1'b1;
            done_p2[tail] <= 1'b0;
            tail          <= tail + IDX_W'(1);
         end
         if (resp_fire)
            done_p2[resp_idx] <= 1'b1;
         if (retire) begin
            busy_p2[head] <= 1'b0;
            head          <= head + IDX_W'(1);
         end

         if (issue && !retire)
            count <= count + CNT_W'(1);
         else if (!issue && retire)
            count <= count - CNT_W'(1);

         if (drain_cnt != '0)
            drain_cnt <= drain_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (d_xfer) begin
         req_p1.pc      <= D.pc;
         req_p1.seq_num <= D.seq_num;
         req_p1.op1     <= D.op1;
         req_p1.op2     <= D.op2;
         req_p1.op3     <= D.op3;
         req_p1.waddr   <= D.waddr;
         req_p1.preg    <= D.preg;
         req_p1.ppreg   <= D.ppreg;
         req_p1.uop     <= D.uop;
      end
      if (issue) begin
         slot_p2[tail].pc      <= req_p1.pc;
         slot_p2[tail].seq_num <= req_p1.seq_num;
         slot_p2[tail].waddr   <= req_p1.waddr;
         slot_p2[tail].preg    <= req_p1.preg;
         slot_p2[tail].ppreg   <= req_p1.ppreg;
         slot_p2[tail].uop     <= req_p1.uop;
         slot_p2[tail].offset  <= offset;
      end
      if (resp_fire)
         slot_p2[resp_idx].raw <= mem.resp_msg.data;
   end

   // ---- stage 3: in-order retire from the head slot ----
   lsu_load_extract u_extract (
      .raw    (slot_p2[head].raw),
      .offset (slot_p2[head].offset),
      .uop    (slot_p2[head].uop),
      .wdata  (ext_wdata)
   );

   always_comb begin
      W.pc      = slot_p2[head].pc;
      W.seq_num = slot_p2[head].seq_num;
      W.waddr   = slot_p2[head].waddr;
      W.preg    = slot_p2[head].preg;
      W.ppreg   = slot_p2[head].ppreg;
      W.wdata   = ext_wdata;
      W.wen     = ~is_store(slot_p2[head].uop);
   end

   // Responses must hit a live slot and carry a zero-extended tag. Stale responses
   // from before a reset are tolerated during the short drain window.
   assert property (@(posedge clk) disable iff (!rst)
      (mem.resp_val && drain_cnt == '0) |->
         (resp_ok && (mem.resp_msg.opaque >> IDX_W) == '0));

   function automatic string trace();
      rv_uop iu;
      rv_uop ru;
      string s_iss;
      string s_ret;
      iu = req_p1.uop;
      ru = slot_p2[head].uop;
      s_iss = issue ? $sformatf("%-7s:%02h:%08h:%08h", iu.name(), req_p1.seq_num,
                                mem.req_msg.addr, mem.req_msg.data)
                    : $sformatf("%28s", "");
      s_ret = retire ? $sformatf("%-7s:%02h:%08h", ru.name(), slot_p2[head].seq_num, ext_wdata)
                     : $sformatf("%19s", "");
      return {s_iss, " | ", s_ret};
   endfunction

endmodule
